// File: rtl/uart_pkg.sv
// Shared UART definitions: serializer state encoding and line constants,
// common to the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   DATA_BITS       = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full or a pop while
// empty is ignored, so callers may drive push/pop without extra gating.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is taken from the registered level, so a pop in the same cycle
    // never lets a push slip into a full FIFO.
    assign full     = (level == FULL_LEVEL);
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers reply bytes in a small FIFO and serializes them
// as 8N1/8N2 frames, LSB first, on a registered tx line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [7:0]                      tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic                            tx,
    output logic                            tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_t    state, state_nxt;
    logic [CW-1:0]  baud_cnt, baud_nxt;
    logic [2:0]     bit_idx, bit_nxt;
    logic [7:0]     shift, shift_nxt;
    logic           tx_nxt;
    logic           baud_done;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_head;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tx_valid),
        .push_data (tx_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign tx_ready  = !fifo_full;
    assign tx_busy   = (state != ST_IDLE) || !fifo_empty;
    assign baud_done = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= UART_IDLE_LEVEL;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_idx  <= bit_nxt;
            shift    <= shift_nxt;
            tx       <= tx_nxt;
        end
    end

    // tx_nxt is the line level for the state being entered, keeping tx a
    // pure register with no path from the handshake inputs.
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        tx_nxt    = tx;
        fifo_pop  = 1'b0;
        case (state)
            ST_IDLE: begin
                tx_nxt = UART_IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_nxt = fifo_head;
                    baud_nxt  = '0;
                    tx_nxt    = 1'b0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    tx_nxt    = shift[0];
                    state_nxt = ST_DATA;
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_idx == LAST_BIT) begin
                        bit_nxt   = '0;
                        tx_nxt    = UART_IDLE_LEVEL;
                        state_nxt = ST_STOP;
                    end else begin
                        bit_nxt   = bit_idx + 1'b1;
                        shift_nxt = {1'b0, shift[7:1]};
                        tx_nxt    = shift[1];
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            ST_STOP: begin
                // bit_idx is reused to count stop bits
                if (baud_done) begin
                    baud_nxt = '0;
                    if (bit_idx == LAST_STOP) begin
                        bit_nxt   = '0;
                        state_nxt = ST_IDLE;
                    end else begin
                        bit_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    baud_nxt = baud_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
